// File: rtl/uart_tx_frame.sv
// UART transmitter: internal baud divider, 5..9 data bits, optional even/odd parity, 1/2 stop bits.
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry TX FIFO in front of the frame register.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              i_Clock,
  input  logic                              rst,
  input  logic                              i_pen,
  input  logic                              i_eps,
  input  logic                              i_stop2,
  input  logic                              i_tx_valid,
  input  logic [DATA_BITS-1:0]              i_tx_data,
  output logic                              o_tx_ready,
  output logic                              o_tx_serial,
  output logic                              o_tx_busy,
  output logic                              o_tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_level
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [BW-1:0]         bit_reg, bit_next;
  logic [DATA_BITS-1:0]  data_reg, data_next;
  logic                  pen_reg, pen_next;
  logic                  eps_reg, eps_next;
  logic                  stop2_reg, stop2_next;

  logic                  bit_end;
  logic                  last_stop;
  logic                  can_take;
  logic                  load;
  logic [DATA_BITS-1:0]  load_data;
  logic                  load_pen;
  logic                  load_eps;
  logic                  load_stop2;

  assign bit_end   = (cnt_reg == CNT_LAST);
  // bit_reg doubles as the stop-bit index while in STOP
  assign last_stop = (state_reg == S_STOP) && bit_end &&
                     (bit_reg == {{(BW-1){1'b0}}, stop2_reg});
  assign can_take  = (state_reg == S_IDLE) || last_stop;

`ifdef UART_TX_FIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);

  logic [DATA_BITS+2:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]        level_reg;
  logic                 push;

  assign o_tx_ready   = (level_reg != LW'(FIFO_DEPTH));
  assign push         = i_tx_valid && o_tx_ready;
  assign load         = (level_reg != '0) && can_take;
  assign o_fifo_level = level_reg;
  assign {load_data, load_pen, load_eps, load_stop2} = mem[rd_ptr_reg];

  always_ff @(posedge i_Clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= {i_tx_data, i_pen, i_eps, i_stop2};
    end
  end

  always_ff @(posedge i_Clock or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (load) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({push, load})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end
`else
  assign o_tx_ready   = can_take;
  assign load         = i_tx_valid && o_tx_ready;
  assign load_data    = i_tx_data;
  assign load_pen     = i_pen;
  assign load_eps     = i_eps;
  assign load_stop2   = i_stop2;
  assign o_fifo_level = '0;
`endif

  always_ff @(posedge i_Clock or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      data_reg  <= '0;
      pen_reg   <= 1'b0;
      eps_reg   <= 1'b0;
      stop2_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      data_reg  <= data_next;
      pen_reg   <= pen_next;
      eps_reg   <= eps_next;
      stop2_reg <= stop2_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    bit_next    = bit_reg;
    data_next   = data_reg;
    pen_next    = pen_reg;
    eps_next    = eps_reg;
    stop2_next  = stop2_reg;
    o_tx_serial = 1'b1;

    case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        bit_next = '0;
      end
      S_START: begin
        o_tx_serial = 1'b0;
        if (bit_end) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = S_DATA;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_DATA: begin
        o_tx_serial = data_reg[bit_reg];
        if (bit_end) begin
          cnt_next = '0;
          if (bit_reg == BIT_LAST) begin
            bit_next   = '0;
            state_next = pen_reg ? S_PARITY : S_STOP;
          end else begin
            bit_next = bit_reg + BW'(1);
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_PARITY: begin
        o_tx_serial = eps_reg ? ^data_reg : ~^data_reg;
        if (bit_end) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = S_STOP;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_STOP: begin
        o_tx_serial = 1'b1;
        if (bit_end) begin
          cnt_next = '0;
          if (last_stop) begin
            bit_next   = '0;
            state_next = S_IDLE;
          end else begin
            bit_next = bit_reg + BW'(1);
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
        bit_next   = '0;
      end
    endcase

    // A new frame overrides the return to IDLE, giving zero idle bits between frames
    if (load) begin
      state_next = S_START;
      cnt_next   = '0;
      bit_next   = '0;
      data_next  = load_data;
      pen_next   = load_pen;
      eps_next   = load_eps;
      stop2_next = load_stop2;
    end
  end

  assign o_tx_busy = (state_reg != S_IDLE);
  assign o_tx_done = last_stop;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Randomised bench for uart_tx_frame: accepted words are queued and each serial frame is
// rebuilt from the frame rules (start, LSB-first data, parity by population count, stops).
module tb_uart_tx_frame;
  localparam int CPB = 4;
  localparam int DB  = 8;
  localparam int FD  = 4;
  localparam int LW  = $clog2(FD+1);
`ifdef UART_TX_FIFO_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          i_Clock;
  logic          rst;
  logic          i_pen;
  logic          i_eps;
  logic          i_stop2;
  logic          i_tx_valid;
  logic [DB-1:0] i_tx_data;
  logic          o_tx_ready;
  logic          o_tx_serial;
  logic          o_tx_busy;
  logic          o_tx_done;
  logic [LW-1:0] o_fifo_level;

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .FIFO_DEPTH(FD)) dut (
    .i_Clock      (i_Clock),
    .rst          (rst),
    .i_pen        (i_pen),
    .i_eps        (i_eps),
    .i_stop2      (i_stop2),
    .i_tx_valid   (i_tx_valid),
    .i_tx_data    (i_tx_data),
    .o_tx_ready   (o_tx_ready),
    .o_tx_serial  (o_tx_serial),
    .o_tx_busy    (o_tx_busy),
    .o_tx_done    (o_tx_done),
    .o_fifo_level (o_fifo_level)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  int cyc = 0;
  always @(posedge i_Clock) cyc <= cyc + 1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  typedef struct {
    logic [DB-1:0] data;
    bit            pen;
    bit            eps;
    bit            stop2;
    int            cyc;
    bit            from_idle;
  } exp_t;

  exp_t exp_q[$];

  // Words are taken at the next rising edge whenever valid & ready holds at the falling edge
  always @(negedge i_Clock) begin
    exp_t e;
    if (!rst && i_tx_valid && o_tx_ready) begin
      e.data      = i_tx_data;
      e.pen       = i_pen;
      e.eps       = i_eps;
      e.stop2     = i_stop2;
      e.cyc       = cyc;
      e.from_idle = !o_tx_busy && (o_fifo_level == '0);
      exp_q.push_back(e);
    end
  end

  task automatic sync();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic scramble();
    i_tx_valid = 1'b0;
    i_tx_data  = DB'($urandom);
    i_pen      = 1'($urandom);
    i_eps      = 1'($urandom);
    i_stop2    = 1'($urandom);
  endtask

  task automatic send(input logic [DB-1:0] d, input bit pen, input bit eps, input bit stop2);
    bit acc;
    acc        = 1'b0;
    i_tx_valid = 1'b1;
    i_tx_data  = d;
    i_pen      = pen;
    i_eps      = eps;
    i_stop2    = stop2;
    for (int t = 0; t < 2000 && !acc; t++) begin
      @(negedge i_Clock);
      acc = o_tx_ready;
      @(posedge i_Clock);
      #1;
    end
    check("accept", 32'(acc), 1);
    scramble();
  endtask

  task automatic rx_frames(input int n, input bit chk_gap);
    exp_t        e;
    int          prev_end, start_cyc, nb, ones, dcnt;
    bit          got, busy_ok, dlast;
    logic [15:0] fb;
    logic [31:0] smp;
    prev_end = 0;
    for (int k = 0; k < n; k++) begin
      got = 1'b0;
      for (int t = 0; t < 600 && !got; t++) begin
        @(negedge i_Clock);
        got = !o_tx_serial;
      end
      check("start_seen", 32'(got), 1);
      if (!got) return;
      check("word_queued", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      start_cyc = cyc;
      if (e.from_idle) check("latency", 32'(start_cyc - e.cyc), LAT);
      if (chk_gap && k > 0) check("gap", 32'(start_cyc - prev_end), 1);

      ones  = $countones(e.data);
      fb    = '0;
      fb[0] = 1'b0;
      nb    = 1;
      for (int i = 0; i < DB; i++) begin
        fb[nb] = e.data[i];
        nb++;
      end
      if (e.pen) begin
        fb[nb] = e.eps ? 1'(ones % 2) : 1'(1 - ones % 2);
        nb++;
      end
      fb[nb] = 1'b1;
      nb++;
      if (e.stop2) begin
        fb[nb] = 1'b1;
        nb++;
      end

      busy_ok = 1'b1;
      dcnt    = 0;
      for (int b = 0; b < nb; b++) begin
        smp = '0;
        for (int c = 0; c < CPB; c++) begin
          if (b != 0 || c != 0) @(negedge i_Clock);
          smp[c]  = o_tx_serial;
          busy_ok = busy_ok && o_tx_busy;
          if (o_tx_done) dcnt++;
        end
        check($sformatf("bit%0d", b), smp, fb[b] ? 32'((1 << CPB) - 1) : 32'd0);
      end
      dlast = o_tx_done;
      check("busy_in_frame", 32'(busy_ok), 1);
      check("done_count", 32'(dcnt), 1);
      check("done_last_clk", 32'(dlast), 1);
      prev_end = cyc;
      $display("frame data=0x%02h pen=%0d eps=%0d stop2=%0d bits=%0d start=%0d",
               e.data, e.pen, e.eps, e.stop2, nb, start_cyc);
    end
  endtask

  initial begin
    bit seen;
    int lows;
    rst = 1'b1;
    scramble();
    repeat (3) @(posedge i_Clock);
    #1;
    check("rst_serial", 32'(o_tx_serial), 1);
    check("rst_ready", 32'(o_tx_ready), 1);
    check("rst_busy", 32'(o_tx_busy), 0);
    check("rst_done", 32'(o_tx_done), 0);
    check("rst_level", 32'(o_fifo_level), 0);
    rst = 1'b0;
    exp_q.delete();

    // Plain frame, 40 clocks
    sync();
    fork
      send(8'h4A, 1'b0, 1'b0, 1'b0);
      rx_frames(1, 1'b0);
    join
    @(negedge i_Clock);
    check("busy_idle_4a", 32'(o_tx_busy), 0);

    // Parity cases
    sync();
    fork
      begin
        send(8'hAE, 1'b1, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0, 1'b0);
        send(8'hFF, 1'b1, 1'b1, 1'b0);
      end
      rx_frames(3, 1'b0);
    join

    // Two stop bits, config flipped while the frame is in flight
    sync();
    fork
      begin
        send(8'h3C, 1'b0, 1'b0, 1'b1);
        i_stop2 = 1'b0;
        i_pen   = 1'b1;
      end
      rx_frames(1, 1'b0);
    join
    @(negedge i_Clock);
    check("busy_idle_stop2", 32'(o_tx_busy), 0);

    // Valid held high across two words
    sync();
    fork
      begin
        send(8'h11, 1'b0, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0, 1'b0);
      end
      rx_frames(2, 1'b1);
    join

    // Five words pushed back to back
    sync();
    fork
      begin
        for (int i = 0; i < 5; i++) send(DB'(8'h50 + i), 1'b0, 1'b0, 1'b0);
`ifdef UART_TX_FIFO_EN
        @(negedge i_Clock);
        check("fifo_full_level", 32'(o_fifo_level), 4);
        check("fifo_full_ready", 32'(o_tx_ready), 0);
        seen = 1'b0;
        for (int t = 0; t < 400 && !seen; t++) begin
          @(negedge i_Clock);
          seen = o_tx_done;
        end
        check("first_done", 32'(seen), 1);
        @(negedge i_Clock);
        check("after_pop_level", 32'(o_fifo_level), 3);
        check("after_pop_ready", 32'(o_tx_ready), 1);
`else
        @(negedge i_Clock);
        check("level_tied", 32'(o_fifo_level), 0);
`endif
      end
      rx_frames(5, 1'b1);
    join

    // Random words, configs and idle gaps
    sync();
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          int g;
          g = $urandom_range(0, 3);
          repeat (g) sync();
          send(DB'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
      end
      rx_frames(12, 1'b0);
    join

    // Reset in the middle of DATA
    sync();
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    repeat (CPB * 4) @(posedge i_Clock);
    #2;
    check("pre_rst_busy", 32'(o_tx_busy), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_serial", 32'(o_tx_serial), 1);
    check("mid_rst_busy", 32'(o_tx_busy), 0);
    check("mid_rst_ready", 32'(o_tx_ready), 1);
    repeat (2) @(posedge i_Clock);
    #1;
    rst = 1'b0;
    exp_q.delete();
    lows = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge i_Clock);
      if (!o_tx_serial) lows++;
    end
    check("no_stray_start", 32'(lows), 0);
    check("post_rst_busy", 32'(o_tx_busy), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
